// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - AES-128 inverse SubBytes stage, LANES inverse S-boxes per cycle
// Optional macro INV_SUB_BYTES_ZERO_BUBBLE_EN: accept the next block in the same cycle the finished one leaves.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  localparam int STEPS = 16 / LANES;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  // FIPS-197 inverse S-box, entry n at bits 8n..8n+7
  localparam logic [0:2047] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{b, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [0:127]  buf_q;
  logic [0:127]  buf_sub;
  logic [CW-1:0] cnt;
  logic          take;
  logic          give;

  assign take = in_valid && in_ready;
  assign give = out_valid && out_ready;

  // Only the LANES bytes of the current group pass through an S-box
  always_comb begin
    buf_sub = buf_q;
    for (int l = 0; l < LANES; l++) begin
      buf_sub[8*(int'(cnt)*LANES + l) +: 8] = inv_sbox(buf_q[8*(int'(cnt)*LANES + l) +: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (take) state_nx = BUSY;
      end
      BUSY: begin
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        if (take) state_nx = BUSY;
        else if (give) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      BUSY: busy = 1'b1;
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = buf_q;
`ifdef INV_SUB_BYTES_ZERO_BUBBLE_EN
        in_ready  = out_ready;
`else
        in_ready  = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt   <= '0;
    end else if (take) begin
      buf_q <= in_data;
      cnt   <= '0;
    end else if (state == BUSY) begin
      buf_q <= buf_sub;
      cnt   <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Inverse SubBytes stage of the AES-128 decryption datapath.
- Sits directly downstream of the inverse ShiftRows stage and takes its 128-bit output unchanged.
- Applies the FIPS-197 inverse S-box to all 16 bytes, LANES bytes per clock, behind a valid/ready handshake. This lets the team trade S-box area against latency.
- Its output feeds the AddRoundKey stage.

Parameters:
- LANES, 4, inverse S-box instances applied per cycle. Legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data holds a block
- in_ready  output  1  block will be accepted this cycle
- in_data  input  [0:127]  state from inverse ShiftRows; byte i = in_data[8*i +: 8], byte 0 at bits 0..7
- out_valid  output  1  out_data holds a finished block
- out_ready  input  1  downstream accepts
- out_data  output  [0:127]  substituted state, same byte ordering
- busy  output  1  high in BUSY or DONE

Behaviour:
- The block holds one 128-bit state register, `buf`, a step counter `cnt` of width clog2(16/LANES), minimum 1 bit, and a 2-bit state: IDLE, BUSY, DONE.
- Reset (asynchronous, rst_n=0):
  - state=IDLE, buf=0, cnt=0.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
  - Reset asserted mid-operation discards the block in flight; no partial output is ever presented.
- IDLE:
  - in_ready=1.
  - When in_valid=1, buf <= in_data, cnt <= 0, and the block moves to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of buf are replaced in place by InvSbox(byte); cnt increments.
  - On the cycle where cnt = 16/LANES-1, the last group is written, cnt wraps to 0 and the block moves to DONE.
- DONE:
  - out_valid=1 and out_data=buf, held stable until out_ready=1.
  - On out_valid && out_ready the block moves to IDLE.
  - in_ready=0 in DONE unless the optional feature is enabled.
- Latency:
  - Input handshake at edge k gives out_valid=1 after edge k+16/LANES.
  - LANES=4: 4 cycles. LANES=16: 1 cycle.
  - Throughput without the optional feature is one block per 16/LANES+2 cycles, out_ready held high.
- Data path rules:
  - out_data is driven only from buf and is otherwise 0 outside DONE; it is a registered output.
  - No combinational path exists from in_* to out_*.
- Inverse S-box:
  - Pure function per FIPS-197 (e.g. 0x00->0x52, 0x01->0x09, 0x63->0x00, 0xff->0x7d).
  - Either a ROM or composite-field inversion is acceptable; it must be combinational within the BUSY cycle.
- Protocol:
  - in_valid may drop or change before acceptance without effect.
  - in_data is sampled only at the handshake edge.
  - out_ready is ignored outside DONE.

Optional Feature:
- Macro: INV_SUB_BYTES_ZERO_BUBBLE_EN
- Defined:
  - In DONE, in_ready = out_ready.
  - If in_valid && out_ready in the same DONE cycle, the finished block is delivered, buf <= in_data, cnt <= 0, and the state goes directly to BUSY. IDLE is skipped.
  - Throughput becomes one block per 16/LANES+1 cycles.
- Undefined:
  - in_ready=0 throughout DONE; the block always passes through IDLE between blocks.

Test Plan:
1. FIPS-197 C.1 vector, LANES=4: in_data=7a9f102789d5f50b2beffd9f3dca4ea7 accepted at edge 0 -> out_valid=1 after edge 4, out_data=bd6e7c3df2b5779e0b61216e8b10b689.
2. Boundary bytes, LANES=1: in_data=00 01 63 ff repeated x4 -> 16 BUSY cycles, then out_data=52 09 00 7d repeated x4.
3. Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0, a concurrent in_valid=1 is not accepted; out_ready=1 -> next cycle IDLE, in_ready=1.
4. Reset mid-BUSY: rst_n pulsed low during step 2 of vector 1 -> all outputs return to reset values immediately; a new block after release yields the correct result with no residue.
5. LANES=16 back-to-back with out_ready=1 and in_valid=1 constantly -> 1-cycle latency; block accepts spaced 3 cycles apart (2 with INV_SUB_BYTES_ZERO_BUBBLE_EN), every output matching the reference InvSbox model.
6. Random 1000 blocks with random valid/ready stalls across all legal LANES values -> scoreboard match, no dropped or duplicated blocks.
